// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART deserializer and its driver/consumer.
// The slave side is the deserializer; the master side drives rx and the tick.
interface uart_rx_if #(
  parameter int DBIT = 8
) ();
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;
  logic            busy;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, parity_err, busy
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampled, LSB-first, optional parity,
// configurable stop length; emits a one-clock done pulse for the receive FIFO.
module uart_rx_deser #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int             NW      = $clog2(DBIT);
  localparam logic [NW-1:0]  N_LAST  = NW'(DBIT - 1);
  localparam logic [4:0]     SB_LAST = 5'(SB_TICK - 1);
  localparam logic           ODD     = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [4:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            p_err;
  logic            rx_p0;
  logic            rx_s;

  // Stage p0/p1: two-flop synchronizer; everything downstream sees rx_s only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_s  <= rx_p0;
    end
  end

  // Shift register is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state == DATA && bus.s_tick && s == 5'd15)
      b <= {rx_s, b[DBIT-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      s                <= '0;
      n                <= '0;
      p_err            <= 1'b0;
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.parity_err   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            s        <= '0;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s == 5'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
                p_err <= 1'b0;
              end else begin
                // Start bit vanished before mid-bit: treat as a glitch.
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s == 5'd15) begin
              s <= '0;
              if (n == N_LAST)
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              else
                n <= n + NW'(1);
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        PARITY: begin
          if (bus.s_tick) begin
            if (s == 5'd15) begin
              s     <= '0;
              p_err <= (^b) ^ rx_s ^ ODD;
              state <= STOP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s == SB_LAST) begin
              state            <= IDLE;
              bus.busy         <= 1'b0;
              bus.dout         <= b;
              bus.rx_done_tick <= 1'b1;
              bus.frame_err    <= ~rx_s;
              bus.parity_err   <= p_err;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: 8N1 instance plus an 8E1 instance,
// s_tick every 4 clocks, frames driven bit-by-bit on tick boundaries.
module tb_uart_rx_deser;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   tcnt = 0;

  uart_rx_if #(.DBIT(8)) ifa ();
  uart_rx_if #(.DBIT(8)) ifb ();

  uart_rx_deser #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );

  uart_rx_deser #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ifa.s_tick = 1'b0;
    ifb.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = tcnt + 1;
      ifa.s_tick = (tcnt % 4 == 0);
      ifb.s_tick = (tcnt % 4 == 0);
    end
  end

  // Pulse monitor: records each done pulse, its cycle and word, and any wide pulse.
  int         pa_cnt = 0;
  int         pb_cnt = 0;
  int         wide_cnt = 0;
  int         pa_cyc[$];
  logic [7:0] pa_dout[$];
  logic       prev_a = 1'b0;
  logic       prev_b = 1'b0;

  always @(negedge clk) begin
    if (ifa.rx_done_tick === 1'b1) begin
      pa_cnt = pa_cnt + 1;
      pa_cyc.push_back(cyc);
      pa_dout.push_back(ifa.dout);
      if (prev_a) wide_cnt = wide_cnt + 1;
    end
    if (ifb.rx_done_tick === 1'b1) begin
      pb_cnt = pb_cnt + 1;
      if (prev_b) wide_cnt = wide_cnt + 1;
    end
    prev_a = (ifa.rx_done_tick === 1'b1);
    prev_b = (ifb.rx_done_tick === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic wait_ticks(input int nt);
    repeat (nt) begin
      @(posedge clk);
      while (ifa.s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) ifb.rx = v;
    else     ifa.rx = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par, input bit stop_low);
    set_rx(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      wait_ticks(16);
    end
    if (par_en) begin
      set_rx(sel, par);
      wait_ticks(16);
    end
    if (stop_low) begin
      set_rx(sel, 1'b0);
      wait_ticks(9);
      set_rx(sel, 1'b1);
      wait_ticks(7);
    end else begin
      set_rx(sel, 1'b1);
      wait_ticks(16);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifa.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", ifa.dout); end
    checks++; if (ifa.rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ifa.rx_done_tick); end
    checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ifa.frame_err); end
    checks++; if (ifa.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", ifa.parity_err); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", ifb.busy); end
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(4);
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", ifa.busy); end
  endtask

  task automatic test_basic();
    int c0;
    int w0;
    c0 = pa_cnt;
    w0 = wide_cnt;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    wait_ticks(2);
    checks++; if (pa_cnt - c0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", pa_cnt - c0); end
    checks++; if (ifa.dout !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h expected a5", ifa.dout); end
    checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", ifa.frame_err); end
    checks++; if (ifa.parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b expected 0", ifa.parity_err); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.rx_done_tick !== 1'b0) begin errors++; $display("FAIL basic_done_low: got %b expected 0", ifa.rx_done_tick); end
    checks++; if (wide_cnt - w0 !== 0) begin errors++; $display("FAIL basic_width: wide pulses got %0d expected 0", wide_cnt - w0); end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = pa_cnt;
    set_rx(1'b0, 1'b0);
    wait_ticks(5);
    set_rx(1'b0, 1'b1);
    wait_ticks(20);
    checks++; if (pa_cnt - c0 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pa_cnt - c0); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout: got %h expected a5", ifa.dout); end
  endtask

  task automatic test_frame_err();
    int c0;
    c0 = pa_cnt;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_ticks(16);
    checks++; if (pa_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", pa_cnt - c0); end
    checks++; if (ifa.dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout: got %h expected 3c", ifa.dout); end
    checks++; if (ifa.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", ifa.frame_err); end
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    wait_ticks(2);
    checks++; if (ifa.dout !== 8'h0F) begin errors++; $display("FAIL ferr_next_dout: got %h expected 0f", ifa.dout); end
    checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b expected 0", ifa.frame_err); end
    checks++; if (pa_cnt - c0 !== 2) begin errors++; $display("FAIL ferr_next_pulses: got %0d expected 2", pa_cnt - c0); end
  endtask

  task automatic test_parity();
    int c0;
    c0 = pb_cnt;
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    wait_ticks(2);
    checks++; if (pb_cnt - c0 !== 1) begin errors++; $display("FAIL par_ok_pulses: got %0d expected 1", pb_cnt - c0); end
    checks++; if (ifb.dout !== 8'h03) begin errors++; $display("FAIL par_ok_dout: got %h expected 03", ifb.dout); end
    checks++; if (ifb.parity_err !== 1'b0) begin errors++; $display("FAIL par_ok_flag: got %b expected 0", ifb.parity_err); end
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
    wait_ticks(2);
    checks++; if (pb_cnt - c0 !== 2) begin errors++; $display("FAIL par_bad_pulses: got %0d expected 2", pb_cnt - c0); end
    checks++; if (ifb.parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", ifb.parity_err); end
    checks++; if (ifb.dout !== 8'h03) begin errors++; $display("FAIL par_bad_dout: got %h expected 03", ifb.dout); end
    checks++; if (ifb.frame_err !== 1'b0) begin errors++; $display("FAIL par_bad_ferr: got %b expected 0", ifb.frame_err); end
  endtask

  task automatic test_back_to_back();
    int c0;
    int w0;
    c0 = pa_cnt;
    w0 = wide_cnt;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    wait_ticks(4);
    checks++; if (pa_cnt - c0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pa_cnt - c0); end
    checks++; if (pa_dout[c0] !== 8'h11) begin errors++; $display("FAIL b2b_word0: got %h expected 11", pa_dout[c0]); end
    checks++; if (pa_dout[c0+1] !== 8'h22) begin errors++; $display("FAIL b2b_word1: got %h expected 22", pa_dout[c0+1]); end
    checks++; if (pa_dout[c0+2] !== 8'h33) begin errors++; $display("FAIL b2b_word2: got %h expected 33", pa_dout[c0+2]); end
    checks++; if (pa_cyc[c0+1] - pa_cyc[c0] !== 640) begin errors++; $display("FAIL b2b_gap01: got %0d clk expected 640", pa_cyc[c0+1] - pa_cyc[c0]); end
    checks++; if (pa_cyc[c0+2] - pa_cyc[c0+1] !== 640) begin errors++; $display("FAIL b2b_gap12: got %0d clk expected 640", pa_cyc[c0+2] - pa_cyc[c0+1]); end
    checks++; if (wide_cnt - w0 !== 0) begin errors++; $display("FAIL b2b_width: wide pulses got %0d expected 0", wide_cnt - w0); end
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = pa_cnt;
    set_rx(1'b0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_rx(1'b0, 1'b1);
      wait_ticks(16);
    end
    set_rx(1'b0, 1'b1);
    wait_ticks(8);
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", ifa.busy); end
    reset = 1'b1;
    #3;
    checks++; if (ifa.dout !== 8'h00) begin errors++; $display("FAIL mid_reset_dout: got %h expected 00", ifa.dout); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_ferr: got %b expected 0", ifa.frame_err); end
    checks++; if (ifb.parity_err !== 1'b0) begin errors++; $display("FAIL mid_reset_perr_b: got %b expected 0", ifb.parity_err); end
    checks++; if (ifb.dout !== 8'h00) begin errors++; $display("FAIL mid_reset_dout_b: got %h expected 00", ifb.dout); end
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(40);
    checks++; if (pa_cnt - c0 !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d expected 0", pa_cnt - c0); end
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    wait_ticks(2);
    checks++; if (pa_cnt - c0 !== 1) begin errors++; $display("FAIL mid_next_pulses: got %0d expected 1", pa_cnt - c0); end
    checks++; if (ifa.dout !== 8'h5A) begin errors++; $display("FAIL mid_next_dout: got %h expected 5a", ifa.dout); end
    checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL mid_next_ferr: got %b expected 0", ifa.frame_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
